// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/LS memory port arbiter.
// Widths here set the default data/address width used by mem_port_arbiter.
package mem_arb_pkg;

   localparam int ARB_XLEN   = 64;
   localparam int ARB_MASK_W = ARB_XLEN / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_e;

   // Memory is doubleword addressed; requesters keep byte-lane selection.
   localparam logic [ARB_XLEN-1:0] ALIGN_MASK = {{(ARB_XLEN-3){1'b1}}, 3'b000};

   function automatic logic [ARB_XLEN-1:0] align_addr(input logic [ARB_XLEN-1:0] addr);
      return addr & ALIGN_MASK;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker for the memory port arbiter.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise LS has fixed priority over IF.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic if_valid,
   input  logic ls_valid,
   input  logic last_grant,
   output logic grant_if,
   output logic grant_ls
);

`ifdef MEM_ARB_RR_EN
   always_comb begin
      grant_if = 1'b0;
      grant_ls = 1'b0;
      if (if_valid && ls_valid) begin
         // On a tie the side that did not win last time goes first.
         if (last_grant == OWN_LS) begin
            grant_if = 1'b1;
         end else begin
            grant_ls = 1'b1;
         end
      end else begin
         grant_if = if_valid;
         grant_ls = ls_valid;
      end
   end
`else
   logic w_unused_last_grant;

   assign w_unused_last_grant = last_grant;

   // LS carries the older instruction, so it always beats IF.
   assign grant_ls = ls_valid;
   assign grant_if = if_valid & ~ls_valid;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one doubleword memory port between instruction fetch and load/store,
// one outstanding transaction at a time. MEM_ARB_RR_EN enables round-robin ties.
//
// state | meaning
// IDLE  | no transaction; arbitrate and accept a requester
// REQ   | present latched request to memory until accepted
// WAIT  | accepted; wait for the single response and route it to the owner
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int XLEN   = ARB_XLEN,
   parameter int MASK_W = XLEN / 8
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [XLEN-1:0]   if_req_addr,
   output logic              if_rsp_valid,
   output logic [XLEN-1:0]   if_rsp_data,

   input  logic              ls_req_valid,
   output logic              ls_req_ready,
   input  logic              ls_req_wen,
   input  logic [XLEN-1:0]   ls_req_addr,
   input  logic [XLEN-1:0]   ls_req_wdata,
   input  logic [MASK_W-1:0] ls_req_wmask,
   output logic              ls_rsp_valid,
   output logic [XLEN-1:0]   ls_rsp_data,

   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_wen,
   output logic [XLEN-1:0]   mem_req_addr,
   output logic [XLEN-1:0]   mem_req_wdata,
   output logic [MASK_W-1:0] mem_req_wmask,
   input  logic              mem_rsp_valid,
   input  logic [XLEN-1:0]   mem_rsp_data
);

   arb_state_e        r_state;
   arb_state_e        w_state_nxt;
   owner_e            r_owner;
   logic              r_wen;
   logic [XLEN-1:0]   r_addr;
   logic [XLEN-1:0]   r_wdata;
   logic [MASK_W-1:0] r_wmask;

   logic              w_last_grant;
   logic              w_grant_if;
   logic              w_grant_ls;
   logic              w_idle;
   logic              w_accept;
   logic              w_rsp_fire;
   logic [XLEN-1:0]   w_if_addr_al;
   logic [XLEN-1:0]   w_ls_addr_al;

   assign w_if_addr_al = if_req_addr & ALIGN_MASK[XLEN-1:0];
   assign w_ls_addr_al = ls_req_addr & ALIGN_MASK[XLEN-1:0];

`ifdef MEM_ARB_RR_EN
   logic r_last_grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= OWN_IF;
      end else if (w_accept) begin
         r_last_grant <= w_grant_ls ? OWN_LS : OWN_IF;
      end
   end

   assign w_last_grant = r_last_grant;
`else
   assign w_last_grant = OWN_IF;
`endif

   mem_arb_pick u_pick (
      .if_valid   (if_req_valid),
      .ls_valid   (ls_req_valid),
      .last_grant (w_last_grant),
      .grant_if   (w_grant_if),
      .grant_ls   (w_grant_ls)
   );

   // Grants and responses are suppressed while reset is held so that a reset
   // landing on a live handshake cannot leak a ready or response pulse.
   assign w_idle     = (r_state == IDLE) & ~rst;
   assign w_accept   = w_idle & (w_grant_if | w_grant_ls);
   assign w_rsp_fire = (r_state == WAIT) & mem_rsp_valid & ~rst;

   assign if_req_ready = w_idle & w_grant_if;
   assign ls_req_ready = w_idle & w_grant_ls;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_owner <= OWN_IF;
         r_wen   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wmask <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_owner <= w_grant_ls ? OWN_LS : OWN_IF;
            r_wen   <= w_grant_ls & ls_req_wen;
            r_addr  <= w_grant_ls ? w_ls_addr_al : w_if_addr_al;
            r_wdata <= w_grant_ls ? ls_req_wdata : '0;
            r_wmask <= w_grant_ls ? ls_req_wmask : '0;
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      mem_req_valid = 1'b0;
      mem_req_wen   = 1'b0;
      mem_req_addr  = '0;
      mem_req_wdata = '0;
      mem_req_wmask = '0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = REQ;
            end
         end
         REQ: begin
            mem_req_valid = 1'b1;
            mem_req_wen   = r_wen;
            mem_req_addr  = r_addr;
            mem_req_wdata = r_wdata;
            mem_req_wmask = r_wmask;
            if (mem_req_ready) begin
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            // Returning to IDLE only after the response keeps a new grant
            // out of the response cycle.
            if (mem_rsp_valid) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      if_rsp_valid = 1'b0;
      if_rsp_data  = '0;
      ls_rsp_valid = 1'b0;
      ls_rsp_data  = '0;
      if (w_rsp_fire) begin
         if (r_owner == OWN_LS) begin
            ls_rsp_valid = 1'b1;
            ls_rsp_data  = r_wen ? '0 : mem_rsp_data;
         end else begin
            if_rsp_valid = 1'b1;
            if_rsp_data  = mem_rsp_data;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: grants push expected memory requests
// and responses; a small memory model answers and the observed traffic is popped and compared.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_valid, if_req_ready;
   logic [63:0] if_req_addr;
   logic        if_rsp_valid;
   logic [63:0] if_rsp_data;
   logic        ls_req_valid, ls_req_ready, ls_req_wen;
   logic [63:0] ls_req_addr, ls_req_wdata;
   logic [7:0]  ls_req_wmask;
   logic        ls_rsp_valid;
   logic [63:0] ls_rsp_data;
   logic        mem_req_valid, mem_req_ready, mem_req_wen;
   logic [63:0] mem_req_addr, mem_req_wdata;
   logic [7:0]  mem_req_wmask;
   logic        mem_rsp_valid;
   logic [63:0] mem_rsp_data;

   mem_port_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .if_req_valid  (if_req_valid),
      .if_req_ready  (if_req_ready),
      .if_req_addr   (if_req_addr),
      .if_rsp_valid  (if_rsp_valid),
      .if_rsp_data   (if_rsp_data),
      .ls_req_valid  (ls_req_valid),
      .ls_req_ready  (ls_req_ready),
      .ls_req_wen    (ls_req_wen),
      .ls_req_addr   (ls_req_addr),
      .ls_req_wdata  (ls_req_wdata),
      .ls_req_wmask  (ls_req_wmask),
      .ls_rsp_valid  (ls_rsp_valid),
      .ls_rsp_data   (ls_rsp_data),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_wen   (mem_req_wen),
      .mem_req_addr  (mem_req_addr),
      .mem_req_wdata (mem_req_wdata),
      .mem_req_wmask (mem_req_wmask),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        owner;
      logic [63:0] data;
      int          lat;
      int          cyc;
   } rsp_exp_t;

   typedef struct {
      logic [63:0] addr;
      logic        wen;
      logic [63:0] wdata;
      logic [7:0]  wmask;
   } req_exp_t;

   rsp_exp_t sb[$];
   req_exp_t mq[$];
   logic     grants[$];

   int   n_vec = 0;
   int   n_miss = 0;
   int   cyc = 0;
   int   bp_cfg, bp_left;
   logic outstanding, req_pending, hold_rsp, rearm, last_own;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mem_data(input logic [63:0] a);
      if (a == 64'h0000_0000_8000_0000) return 64'h1122_3344_5566_7788;
      return {a[31:0] ^ 32'h5A5A_5A5A, ~a[31:0]};
   endfunction

   function automatic logic exp_winner_ls();
`ifdef MEM_ARB_RR_EN
      if (if_req_valid && ls_req_valid) return (last_own == 1'b0);
`endif
      return ls_req_valid;
   endfunction

   task automatic check_quiet(input string tag);
      chk({tag, "_if_req_ready"},  {63'd0, if_req_ready},  64'd0);
      chk({tag, "_ls_req_ready"},  {63'd0, ls_req_ready},  64'd0);
      chk({tag, "_if_rsp_valid"},  {63'd0, if_rsp_valid},  64'd0);
      chk({tag, "_ls_rsp_valid"},  {63'd0, ls_rsp_valid},  64'd0);
      chk({tag, "_mem_req_valid"}, {63'd0, mem_req_valid}, 64'd0);
      chk({tag, "_mem_req_wen"},   {63'd0, mem_req_wen},   64'd0);
      chk({tag, "_if_rsp_data"},   if_rsp_data,            64'd0);
      chk({tag, "_ls_rsp_data"},   ls_rsp_data,            64'd0);
      chk({tag, "_mem_req_addr"},  mem_req_addr,           64'd0);
      chk({tag, "_mem_req_wdata"}, mem_req_wdata,          64'd0);
      chk({tag, "_mem_req_wmask"}, {56'd0, mem_req_wmask}, 64'd0);
   endtask

   // One clock: observe and score just before the edge, then update the
   // memory model and requesters just after it.
   task automatic tick();
      logic        acc, acc_wen, g_if, g_ls, busy;
      logic [63:0] acc_addr;
      rsp_exp_t    e;
      req_exp_t    m;
      acc = 1'b0; acc_wen = 1'b0; acc_addr = '0; g_if = 1'b0; g_ls = 1'b0;
      #1;
      cyc++;
      busy = outstanding;
      if (busy) chk("grant_while_busy", {63'd0, if_req_ready | ls_req_ready}, 64'd0);

      if (if_rsp_valid || ls_rsp_valid) begin
         chk("rsp_onehot", {63'd0, if_rsp_valid & ls_rsp_valid}, 64'd0);
         if (sb.size() == 0) begin
            chk("rsp_unexpected", {63'd0, if_rsp_valid | ls_rsp_valid}, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("rsp_owner", {63'd0, ls_rsp_valid}, {63'd0, e.owner});
            chk("rsp_data", ls_rsp_valid ? ls_rsp_data : if_rsp_data, e.data);
            chk("rsp_latency", 64'(cyc - e.cyc), 64'(e.lat));
         end
         outstanding = 1'b0;
      end else begin
         chk("if_rsp_data_quiet", if_rsp_data, 64'd0);
         chk("ls_rsp_data_quiet", ls_rsp_data, 64'd0);
      end

      if (req_pending) chk("mem_req_valid_held", {63'd0, mem_req_valid}, 64'd1);
      if (mem_req_valid) begin
         if (mq.size() == 0) begin
            chk("mem_req_unexpected", {63'd0, mem_req_valid}, 64'd0);
         end else begin
            m = mq[0];
            chk("mem_req_addr", mem_req_addr, m.addr);
            chk("mem_req_wen", {63'd0, mem_req_wen}, {63'd0, m.wen});
            chk("mem_req_wmask", {56'd0, mem_req_wmask}, {56'd0, m.wmask});
            if (m.wen) chk("mem_req_wdata", mem_req_wdata, m.wdata);
            if (mem_req_ready) begin
               acc = 1'b1;
               acc_addr = mem_req_addr;
               acc_wen = mem_req_wen;
               void'(mq.pop_front());
               req_pending = 1'b0;
            end
         end
      end

      if (!busy && !rst && (if_req_valid || ls_req_valid))
         chk("grant_issued", {63'd0, if_req_ready | ls_req_ready}, 64'd1);
      if (if_req_ready || ls_req_ready) begin
         chk("ready_onehot", {63'd0, if_req_ready & ls_req_ready}, 64'd0);
         chk("ready_needs_valid",
             {63'd0, (if_req_ready & ~if_req_valid) | (ls_req_ready & ~ls_req_valid)}, 64'd0);
         chk("grant_winner", {63'd0, ls_req_ready}, {63'd0, exp_winner_ls()});
         g_ls = ls_req_ready;
         g_if = ~ls_req_ready;
         e.owner = g_ls;
         e.cyc   = cyc;
         e.lat   = 2 + bp_cfg;
         if (g_ls) e.data = ls_req_wen ? 64'd0 : mem_data(ls_req_addr & ~64'h7);
         else      e.data = mem_data(if_req_addr & ~64'h7);
         sb.push_back(e);
         m.addr  = (g_ls ? ls_req_addr : if_req_addr) & ~64'h7;
         m.wen   = g_ls & ls_req_wen;
         m.wdata = g_ls ? ls_req_wdata : 64'd0;
         m.wmask = g_ls ? ls_req_wmask : 8'd0;
         mq.push_back(m);
         grants.push_back(g_ls);
         last_own    = g_ls;
         outstanding = 1'b1;
         req_pending = 1'b1;
         bp_left     = bp_cfg;
      end

      @(posedge clk);
      #1;
      if (rst) last_own = 1'b0;
      mem_rsp_valid = acc & ~hold_rsp;
      mem_rsp_data  = mem_rsp_valid ? (acc_wen ? 64'hFFFF_0000_DEAD_BEEF : mem_data(acc_addr))
                                    : 64'h0BAD_0BAD_0BAD_0BAD;
      if (req_pending && bp_left > 0) begin
         mem_req_ready = 1'b0;
         bp_left--;
      end else begin
         mem_req_ready = req_pending;
      end
      if (g_ls) begin
         if (rearm) ls_req_addr = ls_req_addr + 64'd8;
         else       ls_req_valid = 1'b0;
      end
      if (g_if) begin
         if (rearm) if_req_addr = if_req_addr + 64'd8;
         else       if_req_valid = 1'b0;
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((if_req_valid || ls_req_valid || outstanding) && n < budget) begin
         tick();
         n++;
      end
      chk("drain_timeout", {63'd0, if_req_valid | ls_req_valid | outstanding}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      logic exp_seq[6];
      rst = 1'b1;
      if_req_valid = 1'b0; if_req_addr = '0;
      ls_req_valid = 1'b0; ls_req_wen = 1'b0; ls_req_addr = '0; ls_req_wdata = '0; ls_req_wmask = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 64'h0BAD_0BAD_0BAD_0BAD;
      bp_cfg = 0; bp_left = 0; outstanding = 1'b0; req_pending = 1'b0;
      hold_rsp = 1'b0; rearm = 1'b0; last_own = 1'b0;
      repeat (3) tick();
      check_quiet("reset");
      rst = 1'b0;
      tick();

      // spurious response while idle
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'h0000_0000_0000_1234;
      tick();

      // IF read alone
      if_req_valid = 1'b1;
      if_req_addr  = 64'h0000_0000_8000_0004;
      drain(20);

      // LS write
      ls_req_valid = 1'b1; ls_req_wen = 1'b1;
      ls_req_addr  = 64'h0000_0000_8000_0010;
      ls_req_wdata = 64'h0000_0000_0000_00AA;
      ls_req_wmask = 8'h01;
      drain(20);
      ls_req_wen = 1'b0;

      // both requesting continuously
      grants.delete();
      if_req_valid = 1'b1; if_req_addr = 64'h0000_0000_8000_1000;
      ls_req_valid = 1'b1; ls_req_addr = 64'h0000_0000_8000_2008; ls_req_wmask = 8'h00;
      rearm = 1'b1;
      n = 0;
      while (grants.size() < 4 && n < 40) begin
         tick();
         n++;
      end
      rearm = 1'b0;
      drain(40);
`ifdef MEM_ARB_RR_EN
      exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
      chk("tie_grant_count", 64'(grants.size()), 64'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < grants.size()) chk($sformatf("tie_grant_%0d", i), {63'd0, grants[i]}, {63'd0, exp_seq[i]});
      end

      // backpressure on an LS write; requester fields change after grant,
      // IF raises and drops valid while the port is busy
      grants.delete();
      bp_cfg = 5;
      ls_req_valid = 1'b1; ls_req_wen = 1'b1;
      ls_req_addr  = 64'h0000_0000_8000_0023;
      ls_req_wdata = 64'h0123_4567_89AB_CDEF;
      ls_req_wmask = 8'hF0;
      tick();
      ls_req_addr  = 64'hFFFF_FFFF_FFFF_FFF8;
      ls_req_wdata = 64'hDEAD_DEAD_DEAD_DEAD;
      ls_req_wmask = 8'hFF;
      tick();
      if_req_valid = 1'b1; if_req_addr = 64'h0000_0000_8000_0300;
      tick();
      tick();
      if_req_valid = 1'b0;
      drain(30);
      chk("bp_grant_count", 64'(grants.size()), 64'd1);
      if (grants.size() > 0) chk("bp_grant_owner", {63'd0, grants[0]}, 64'd1);
      ls_req_wen = 1'b0; ls_req_wmask = 8'h00;

      // spurious response while in REQ
      bp_cfg = 3;
      if_req_valid = 1'b1; if_req_addr = 64'h0000_0000_8000_0040;
      tick();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'h0000_0000_0000_0BAD;
      tick();
      drain(20);
      bp_cfg = 0;

      // reset while waiting for a response, then a stale response
      hold_rsp = 1'b1;
      if_req_valid = 1'b1; if_req_addr = 64'h0000_0000_8000_0080;
      tick();
      tick();
      chk("wait_reached", {63'd0, req_pending}, 64'd0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      hold_rsp = 1'b0;
      sb.delete(); mq.delete();
      outstanding = 1'b0; req_pending = 1'b0; mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'h0000_0000_0000_5555;
      tick();
      check_quiet("post_rst");
      if_req_valid = 1'b1; if_req_addr = 64'h0000_0000_8000_00C0;
      #1;
      chk("idle_after_rst_ready", {63'd0, if_req_ready}, 64'd1);
      drain(20);

      // mixed traffic
      for (int k = 0; k < 8; k++) begin
         bp_cfg = int'($urandom_range(0, 2));
         if_req_valid = 1'($urandom_range(0, 1));
         ls_req_valid = ~if_req_valid | 1'($urandom_range(0, 1));
         if_req_addr  = {32'd0, 32'h8000_0000 | 32'($urandom_range(0, 4095))};
         ls_req_addr  = {32'd0, 32'h8000_4000 | 32'($urandom_range(0, 4095))};
         ls_req_wen   = 1'($urandom_range(0, 1));
         ls_req_wdata = {$urandom, $urandom};
         ls_req_wmask = 8'($urandom_range(0, 255));
         drain(40);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one 64-bit data-memory port between the instruction fetch requester (IF) and the load/store requester (LS).
- Sits between the fetch stage, the LSU, and the memory model or bus bridge.
- Serialises accesses with one outstanding transaction, latches request fields, and routes each response back to its owner.
- Memory addresses are doubleword-aligned; byte lane selection stays in the requesters.

Parameters:
- XLEN, 64, data and address width.
- MASK_W, XLEN/8, write byte-mask width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req_valid  in  1  IF read request.
- if_req_ready  out  1  IF request accepted this cycle.
- if_req_addr  in  XLEN  IF byte address.
- if_rsp_valid  out  1  IF read data valid, one-cycle pulse.
- if_rsp_data  out  XLEN  IF read doubleword.
- ls_req_valid  in  1  LS request.
- ls_req_ready  out  1  LS request accepted this cycle.
- ls_req_wen  in  1  1 = write, 0 = read.
- ls_req_addr  in  XLEN  LS byte address.
- ls_req_wdata  in  XLEN  LS write doubleword, already lane-merged.
- ls_req_wmask  in  MASK_W  LS byte enables.
- ls_rsp_valid  out  1  LS completion pulse (reads and writes).
- ls_rsp_data  out  XLEN  LS read doubleword; 0 for writes.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_req_wen  out  1  write enable.
- mem_req_addr  out  XLEN  aligned address (addr & ~7).
- mem_req_wdata  out  XLEN  write data.
- mem_req_wmask  out  MASK_W  byte enables.
- mem_rsp_valid  in  1  memory response; exactly one per accepted request.
- mem_rsp_data  in  XLEN  memory read data.

Behaviour:
- Clock and reset: single clock clk; synchronous active-high rst.
- Reset values:
  - state = IDLE.
  - owner = IF.
  - Request latches = 0.
  - All *_ready, *_valid and data outputs = 0.
- IDLE state:
  - Arbitrate among the valid requesters.
  - Assert the winner's *_req_ready combinationally in this cycle.
  - Latch the winner's addr/wen/wdata/wmask and set owner.
  - Next state = REQ.
  - If the winner is IF, latch wen = 0 and wmask = 0.
  - If neither requester is valid, stay in IDLE.
- Arbitration: fixed priority, LS wins over IF when both are valid, because LS holds the older instruction.
- REQ state:
  - mem_req_valid = 1; mem_req_* come from the latches and are stable while waiting.
  - On mem_req_ready = 1, go to WAIT.
  - Otherwise hold REQ indefinitely.
- WAIT state:
  - On mem_rsp_valid = 1, route the response to the owner. The owner's *_rsp_valid = 1 in the same cycle, combinationally.
  - For a read: rsp_data = mem_rsp_data.
  - For an LS write: ls_rsp_data = 0.
  - Then go to IDLE.
- Response outputs: the non-owner's rsp_valid and rsp_data are always 0.
- Latency and throughput:
  - Minimum: accept cycle, then REQ with ready, then response in the next cycle, so a response arrives 2 cycles after accept.
  - Throughput is at most 1 transaction per 3 cycles.
  - No new grant is issued in the cycle a response is returned.
- Ignored memory responses: mem_rsp_valid in IDLE or REQ is ignored (protocol error, no state change).
- Requester contract: requesters hold *_req_valid and their fields stable until ready. The arbiter tolerates valid dropping before grant.
- Reset in REQ or WAIT: return to IDLE and drop the transaction. No rsp pulse is produced. A stale mem_rsp_valid after reset is ignored.
- Simultaneous events: a response in WAIT plus new requests are handled as response this cycle, arbitration next cycle.

Optional Feature:
- MEM_ARB_RR_EN defined:
  - Round-robin arbitration using a last_grant register.
  - When both requesters are valid, grant the one not granted last.
  - last_grant resets to IF, so LS wins the first tie.
  - A single valid requester always wins.
- MEM_ARB_RR_EN undefined: fixed LS-over-IF priority; no last_grant flop.

Decomposition:
- Shared package mem_arb_pkg:
  - State enum IDLE/REQ/WAIT, 2 bits.
  - Owner encoding OWN_IF = 0, OWN_LS = 1.
  - ALIGN_MASK = ~XLEN'h7.
  - XLEN comes from the existing defines.
- Sub-module mem_arb_pick:
  - Combinational picker.
  - Inputs: if_valid, ls_valid, last_grant.
  - Outputs: grant_if, grant_ls, one-hot or none.
  - Holds the MEM_ARB_RR_EN variant.

Test Plan:
- IF read alone: if addr 0x8000_0004, mem_req_ready = 1 immediately, rsp 0x1122334455667788 one cycle later.
  -> mem_req_addr = 0x8000_0000, wen = 0.
  -> if_rsp_valid pulses 2 cycles after if_req_ready with that data; ls_rsp_valid stays 0.
- LS write: addr 0x8000_0010, wdata 0xAA, wmask 0x01.
  -> mem_req_wen = 1, wmask = 0x01.
  -> ls_rsp_valid pulses with data 0 upon mem_rsp_valid.
- Simultaneous IF and LS requests held 10 cycles (fixed priority).
  -> LS granted first, IF granted next IDLE.
  -> With MEM_ARB_RR_EN, grants alternate LS, IF, LS, IF.
- Backpressure: mem_req_ready held 0 for 5 cycles.
  -> mem_req_valid stays 1 with unchanged addr/data.
  -> No further req_ready is asserted.
- Reset in WAIT: assert rst 1 cycle, then drive mem_rsp_valid.
  -> No rsp pulse; state IDLE; all outputs 0.
- Spurious mem_rsp_valid in IDLE and in REQ -> ignored, no rsp pulses, state unchanged.
